// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared encodings for the CPU control stage: opcode/funct
//                values, datapath select encodings, FSM state and error
//                codes, plus the packed control-bundle type and helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_IN    = 6'b111100;
    localparam logic [5:0] OP_OUT   = 6'b111101;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation select
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // Next-PC select
    localparam logic [2:0] PC_NEXT = 3'b000;
    localparam logic [2:0] PC_BEQ  = 3'b001;
    localparam logic [2:0] PC_BNE  = 3'b010;
    localparam logic [2:0] PC_J    = 3'b011;
    localparam logic [2:0] PC_JR   = 3'b100;

    // Sign-extender source select
    localparam logic [1:0] SE_IMM    = 2'b00;
    localparam logic [1:0] SE_SWITCH = 2'b01;
    localparam logic [1:0] SE_PC     = 2'b10;

    // Sticky error code
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_WAIT_IN = 2'b01,
        ST_HALTED  = 2'b10,
        ST_TRAP    = 2'b11
    } state_t;

    // Every datapath select/enable except halt and err
    typedef struct packed {
        logic       sreg;
        logic       smux5;
        logic [1:0] smux16;
        logic       smux32;
        logic [2:0] smuxPC;
        logic [3:0] salu;
        logic       smem;
        logic       sdisplay;
        logic       smemtoreg;
    } ctrl_t;

    // Selects used by IN: switches -> SE16 -> ALU B -> pass-B -> rt
    function automatic ctrl_t in_ctrl();
        ctrl_t c;
        c        = '0;
        c.smux5  = 1'b1;
        c.smux16 = SE_SWITCH;
        c.smux32 = 1'b1;
        c.salu   = ALU_PASSB;
        return c;
    endfunction

    // Keep the selects, suppress every architectural write
    function automatic ctrl_t write_off(input ctrl_t c);
        ctrl_t r;
        r          = c;
        r.sreg     = 1'b0;
        r.smem     = 1'b0;
        r.sdisplay = 1'b0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bus between the datapath and the control stage.
//                master : datapath side (drives inst/flags/button)
//                slave  : control_unit (drives selects, enables, halt, err)
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
    logic [31:0] inst;
    logic        zero;
    logic        of;
    logic        confirm;
    logic        halt;
    logic        sreg;
    logic        smux5;
    logic [1:0]  smux16;
    logic        smux32;
    logic [2:0]  smuxPC;
    logic [3:0]  salu;
    logic        smem;
    logic        sdisplay;
    logic        smemtoreg;
    logic [1:0]  err;

    modport master (
        output inst, zero, of, confirm,
        input  halt, sreg, smux5, smux16, smux32, smuxPC, salu,
               smem, sdisplay, smemtoreg, err
    );

    modport slave (
        input  inst, zero, of, confirm,
        output halt, sreg, smux5, smux16, smux32, smuxPC, salu,
               smem, sdisplay, smemtoreg, err
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronises an asynchronous push-button, debounces it and
//                emits a one-cycle pulse on each accepted rising edge.
//  Ports       : clk, reset (sync, active-high), confirm (raw button),
//                confirm_pulse (one-cycle accepted press)
//  Revision    : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic confirm,
    output logic      confirm_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    // The debounced level only moves after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= confirm;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_max) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_pulse <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign confirm_pulse = r_pulse;
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Sequenced control stage of the CPU. Decodes opcode/funct
//                into datapath selects and runs a small FSM for IN stalls,
//                HLT and overflow/illegal-opcode traps.
//  Ports       : clk, reset (sync, active-high)
//                bus (control_unit_if.slave): inst, zero, of, confirm in;
//                halt, sreg, smux5, smux16, smux32, smuxPC, salu, smem,
//                sdisplay, smemtoreg, err out
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    control_unit_if.slave   bus
);
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    ctrl_t      w_dec;
    logic       w_legal;
    logic       w_ovf_op;
    logic       w_ovf;
    logic       w_is_in;
    logic       w_is_hlt;
    ctrl_t      w_ctrl;
    logic       w_halt;
    logic       w_confirm_pulse;
    state_t     r_state;
    logic [1:0] r_err;
    logic       w_unused;

    assign w_opcode = bus.inst[31:26];
    assign w_funct  = bus.inst[5:0];
    // Register fields and the zero flag are consumed by the datapath only
    assign w_unused = ^{bus.inst[25:6], bus.zero};

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .clk           (clk),
        .reset         (reset),
        .confirm       (bus.confirm),
        .confirm_pulse (w_confirm_pulse)
    );

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec    = '0;
        w_legal  = 1'b1;
        w_ovf_op = 1'b0;
        w_is_in  = 1'b0;
        w_is_hlt = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_dec.sreg = 1'b1;
                case (w_funct)
                    FN_ADD: begin
                        w_dec.salu = ALU_ADD;
                        w_ovf_op   = 1'b1;
                    end
                    FN_SUB: begin
                        w_dec.salu = ALU_SUB;
                        w_ovf_op   = 1'b1;
                    end
                    FN_AND: w_dec.salu = ALU_AND;
                    FN_OR:  w_dec.salu = ALU_OR;
                    FN_SLT: w_dec.salu = ALU_SLT;
                    FN_SLL: w_dec.salu = ALU_SLL;
                    FN_SRL: w_dec.salu = ALU_SRL;
                    FN_JR: begin
                        w_dec.sreg   = 1'b0;
                        w_dec.smuxPC = PC_JR;
                    end
                    default: begin
                        w_dec   = '0;
                        w_legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                w_dec.sreg   = 1'b1;
                w_dec.smux5  = 1'b1;
                w_dec.smux32 = 1'b1;
                w_dec.salu   = ALU_ADD;
                w_ovf_op     = 1'b1;
            end
            OP_LW: begin
                w_dec.sreg      = 1'b1;
                w_dec.smux5     = 1'b1;
                w_dec.smux32    = 1'b1;
                w_dec.salu      = ALU_ADD;
                w_dec.smemtoreg = 1'b1;
            end
            OP_SW: begin
                w_dec.smem   = 1'b1;
                w_dec.smux32 = 1'b1;
                w_dec.salu   = ALU_ADD;
            end
            OP_BEQ: begin
                w_dec.salu   = ALU_SUB;
                w_dec.smuxPC = PC_BEQ;
            end
            OP_BNE: begin
                w_dec.salu   = ALU_SUB;
                w_dec.smuxPC = PC_BNE;
            end
            OP_J:   w_dec.smuxPC = PC_J;
            OP_IN: begin
                w_dec   = in_ctrl();
                w_is_in = 1'b1;
            end
            OP_OUT: w_dec.sdisplay = 1'b1;
            OP_HLT: w_is_hlt = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_ovf = w_ovf_op & bus.of;

    // ------------------------------------------------------------------
    // State-dependent output qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = w_dec;
        w_halt = 1'b0;
        if (reset) begin
            w_ctrl = write_off(w_dec);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_legal || w_ovf) begin
                        w_ctrl = write_off(w_dec);
                        w_halt = 1'b1;
                    end else if (w_is_hlt || w_is_in) begin
                        w_halt = 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    // Selects stay on the IN path; the write and PC advance
                    // happen together in the accepted-press cycle.
                    w_ctrl = in_ctrl();
                    if (w_confirm_pulse) begin
                        w_ctrl.sreg = 1'b1;
                    end else begin
                        w_halt = 1'b1;
                    end
                end
                default: begin
                    w_ctrl = write_off(w_dec);
                    w_halt = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_err   <= ERR_NONE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_legal) begin
                        r_state <= ST_TRAP;
                        r_err   <= ERR_ILL;
                    end else if (w_ovf) begin
                        r_state <= ST_TRAP;
                        r_err   <= ERR_OVF;
                    end else if (w_is_hlt) begin
                        r_state <= ST_HALTED;
                    end else if (w_is_in) begin
                        r_state <= ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    if (w_confirm_pulse) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                ST_TRAP:   r_state <= ST_TRAP;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.halt      = w_halt;
    assign bus.sreg      = w_ctrl.sreg;
    assign bus.smux5     = w_ctrl.smux5;
    assign bus.smux16    = w_ctrl.smux16;
    assign bus.smux32    = w_ctrl.smux32;
    assign bus.smuxPC    = w_ctrl.smuxPC;
    assign bus.salu      = w_ctrl.salu;
    assign bus.smem      = w_ctrl.smem;
    assign bus.sdisplay  = w_ctrl.sdisplay;
    assign bus.smemtoreg = w_ctrl.smemtoreg;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit with DEBOUNCE_CYCLES=4.
//                A behavioural model predicts every output each cycle;
//                directed sequences pin hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;
    localparam int D = 4;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_IN   = 32'hF0030000;
    localparam logic [31:0] I_HLT  = 32'hFC000000;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000010;

    // Mnemonic indices; ADD..SRL are in ALU-code order
    localparam int M_ILL = 0, M_ADD = 1, M_SUB = 2, M_AND = 3, M_OR = 4,
                   M_SLT = 5, M_SLL = 6, M_SRL = 7, M_JR = 8, M_ADDI = 9,
                   M_LW = 10, M_SW = 11, M_BEQ = 12, M_BNE = 13, M_J = 14,
                   M_IN = 15, M_OUT = 16, M_HLT = 17;

    // Bit positions of write enables in the 15-bit control vector
    localparam int B_SREG = 14, B_SMEM = 2, B_SDISP = 1;

    localparam int S_RUN = 0, S_WAIT = 1, S_HALTED = 2, S_TRAP = 3;

    logic clk;
    logic reset;
    control_unit_if bus ();

    control_unit #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference decode ----------------
    logic [5:0] fn_t [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b000000, 6'b000010, 6'b001000};
    logic [5:0] op_t [9] = '{6'b001000, 6'b100011, 6'b101011, 6'b000100,
                             6'b000101, 6'b000010, 6'b111100, 6'b111101, 6'b111111};

    function automatic int mnem(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'b000000) begin
            for (int k = 0; k < 8; k++) if (fn == fn_t[k]) return M_ADD + k;
            return M_ILL;
        end
        for (int k = 0; k < 9; k++) if (op == op_t[k]) return M_ADDI + k;
        return M_ILL;
    endfunction

    // {sreg, smux5, smux16[2], smux32, smuxPC[3], salu[4], smem, sdisplay, smemtoreg}
    function automatic logic [14:0] ref_ctrl(input int m);
        logic sreg, s5, s32, smem, sdisp, smtr;
        logic [1:0] s16;
        logic [2:0] pc;
        logic [3:0] alu;
        {sreg, s5, s32, smem, sdisp, smtr} = '0;
        s16 = 2'd0; pc = 3'd0; alu = 4'd0;
        if (m >= M_ADD && m <= M_SRL) begin
            sreg = 1'b1;
            alu  = 4'(m - M_ADD);
        end
        case (m)
            M_JR:   pc = 3'd4;
            M_ADDI: begin sreg = 1'b1; s5 = 1'b1; s32 = 1'b1; end
            M_LW:   begin sreg = 1'b1; s5 = 1'b1; s32 = 1'b1; smtr = 1'b1; end
            M_SW:   begin smem = 1'b1; s32 = 1'b1; end
            M_BEQ:  begin alu = 4'd1; pc = 3'd1; end
            M_BNE:  begin alu = 4'd1; pc = 3'd2; end
            M_J:    pc = 3'd3;
            M_IN:   begin s5 = 1'b1; s16 = 2'd1; s32 = 1'b1; alu = 4'd7; end
            M_OUT:  sdisp = 1'b1;
            default: ;
        endcase
        return {sreg, s5, s16, s32, pc, alu, smem, sdisp, smtr};
    endfunction

    function automatic bit ovf_op(input int m);
        return (m == M_ADD) || (m == M_SUB) || (m == M_ADDI);
    endfunction

    // ---------------- behavioural model ----------------
    int         m_state;
    logic [1:0] m_err;
    bit         m_pulse, m_s1, m_s2, m_level, m_valid, m_sample, m_flip;
    bit         m_hist [$];
    int         m_m;

    always @(posedge clk) begin
        if (reset) begin
            m_state = S_RUN;
            m_err   = 2'b00;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0;
            m_hist.delete();
            m_valid = 1;
        end else if (m_valid) begin
            m_m = mnem(bus.inst);
            case (m_state)
                S_RUN: begin
                    if (m_m == M_ILL) begin m_state = S_TRAP; m_err = 2'b10; end
                    else if (ovf_op(m_m) && bus.of) begin m_state = S_TRAP; m_err = 2'b01; end
                    else if (m_m == M_HLT) m_state = S_HALTED;
                    else if (m_m == M_IN) m_state = S_WAIT;
                end
                S_WAIT: if (m_pulse) m_state = S_RUN;
                default: ;
            endcase
            // Button: two-stage delay, then accepted once the last D
            // synchronised samples all disagree with the current level.
            m_sample = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.confirm;
            m_hist.push_back(m_sample);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            m_flip = (m_hist.size() == D);
            foreach (m_hist[k]) if (m_hist[k] == m_level) m_flip = 0;
            m_pulse = 0;
            if (m_flip) begin
                m_level = ~m_level;
                m_pulse = m_level;
            end
        end
    end

    logic [14:0] e_c;
    logic        e_h;
    int          e_m;

    always @(negedge clk) begin
        if (m_valid) begin
            e_m = mnem(bus.inst);
            e_c = ref_ctrl(e_m);
            e_h = 1'b0;
            if (reset) begin
                e_c[B_SREG] = 0; e_c[B_SMEM] = 0; e_c[B_SDISP] = 0;
            end else begin
                case (m_state)
                    S_RUN: begin
                        if (e_m == M_ILL || (ovf_op(e_m) && bus.of)) begin
                            e_c[B_SREG] = 0; e_c[B_SMEM] = 0; e_c[B_SDISP] = 0;
                            e_h = 1'b1;
                        end else if (e_m == M_HLT || e_m == M_IN) begin
                            e_h = 1'b1;
                        end
                    end
                    S_WAIT: begin
                        e_c = ref_ctrl(M_IN);
                        if (m_pulse) e_c[B_SREG] = 1'b1;
                        else e_h = 1'b1;
                    end
                    default: begin
                        e_c[B_SREG] = 0; e_c[B_SMEM] = 0; e_c[B_SDISP] = 0;
                        e_h = 1'b1;
                    end
                endcase
            end
            check("cycle_model",
                  {14'd0, bus.halt, bus.sreg, bus.smux5, bus.smux16, bus.smux32, bus.smuxPC,
                   bus.salu, bus.smem, bus.sdisplay, bus.smemtoreg, bus.err},
                  {14'd0, e_h, e_c, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] i, input logic o, input logic c, input logic r);
        @(posedge clk);
        #2;
        bus.inst = i; bus.of = o; bus.confirm = c; reset = r;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 21);
        if (k < 8) return {6'b000000, r[25:6], fn_t[k]};
        if (k < 17) return {op_t[k - 8], r[25:0]};
        if (k < 20) return {6'b111100, r[25:0]};
        return r;
    endfunction

    int  cnt, hold;
    bit  cv, did_reset;

    initial begin
        m_valid = 0;
        reset = 1'b1;
        bus.inst = I_ADD; bus.of = 1'b0; bus.zero = 1'b0; bus.confirm = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_halt", bus.halt, 0);
        check("rst_sreg", bus.sreg, 0);
        check("rst_err", bus.err, 0);

        // 1: add in RUN
        drive(I_ADD, 0, 0, 0);
        @(negedge clk);
        check("add_sreg", bus.sreg, 1);
        check("add_smux5", bus.smux5, 0);
        check("add_smux32", bus.smux32, 0);
        check("add_salu", bus.salu, 0);
        check("add_smuxPC", bus.smuxPC, 0);
        check("add_halt", bus.halt, 0);

        // 2: in, glitch, then a genuine press
        drive(I_IN, 0, 0, 0);
        @(negedge clk);
        check("in_halt", bus.halt, 1);
        check("in_sreg", bus.sreg, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(I_IN, 0, (i < 2), 0);
            @(negedge clk);
            if (bus.sreg) cnt++;
        end
        check("glitch_writes", cnt, 0);
        cnt = 0;
        bus.confirm = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive((cnt == 0) ? I_IN : I_ADD, 0, (i < 8), 0);
            @(negedge clk);
            if (cnt == 0 && bus.sreg) begin
                cnt++;
                check("press_smux16", bus.smux16, 1);
                check("press_smux5", bus.smux5, 1);
                check("press_halt", bus.halt, 0);
            end else if (bus.sreg && bus.smux16 == 2'b01) begin
                cnt++;
            end
        end
        check("press_writes", cnt, 1);
        check("press_back_run", bus.halt, 0);

        // 3: hlt
        drive(I_HLT, 0, 0, 0);
        @(negedge clk);
        check("hlt_halt", bus.halt, 1);
        for (int i = 0; i < 5; i++) begin
            drive(rand_inst(), 0, 0, 0);
            @(negedge clk);
            check("halted_halt", bus.halt, 1);
            check("halted_sreg", bus.sreg, 0);
        end
        drive(I_ADD, 0, 0, 1);
        @(negedge clk);
        check("hlt_rst_halt", bus.halt, 0);
        drive(I_ADD, 0, 0, 0);
        @(negedge clk);
        check("hlt_exit_halt", bus.halt, 0);
        check("hlt_exit_sreg", bus.sreg, 1);

        // 4: addi overflow trap
        drive(I_ADDI, 1, 0, 0);
        @(negedge clk);
        check("ovf_sreg", bus.sreg, 0);
        check("ovf_halt", bus.halt, 1);
        for (int i = 0; i < 10; i++) begin
            drive(rand_inst(), $urandom_range(0, 1), 0, 0);
            @(negedge clk);
            check("trap_err", bus.err, 1);
            check("trap_halt", bus.halt, 1);
        end

        // 5: sw, beq, j
        drive(I_ADD, 0, 0, 1);
        drive(I_SW, 0, 0, 0);
        @(negedge clk);
        check("sw_smem", bus.smem, 1);
        check("sw_sreg", bus.sreg, 0);
        check("sw_err", bus.err, 0);
        drive(I_BEQ, 0, 0, 0);
        @(negedge clk);
        check("beq_smuxPC", bus.smuxPC, 1);
        check("beq_salu", bus.salu, 1);
        drive(I_J, 0, 0, 0);
        @(negedge clk);
        check("j_smuxPC", bus.smuxPC, 3);

        // 6: reset coincides with the accepted press
        drive(I_IN, 0, 1, 0);
        cnt = 0;
        did_reset = 0;
        for (int i = 0; i < 20 && !did_reset; i++) begin
            @(posedge clk);
            #2;
            reset = m_pulse;
            did_reset = m_pulse;
            @(negedge clk);
            if (bus.sreg) cnt++;
        end
        check("rstpress_seen", did_reset, 1);
        check("rstpress_writes", cnt, 0);
        drive(I_ADD, 0, 0, 0);
        @(negedge clk);
        check("rstpress_run", bus.halt, 0);
        check("rstpress_err", bus.err, 0);

        // Randomised phase against the model
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                cv   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            drive(rand_inst(), ($urandom_range(0, 5) == 0), cv, ($urandom_range(0, 29) == 0));
        end
        drive(I_ADD, 0, 0, 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
